// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scanner with a double-buffered frame and dead-time blanking.
// Optional blinking of masked digits is compiled in with SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 12500,
  parameter int unsigned DEAD_CYC     = 64,
  parameter int unsigned BLINK_FRAMES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [31:0] frame_code,
  input  logic [7:0]  frame_en,
  input  logic [7:0]  frame_dp,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 3;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] code;
    logic [7:0]  en;
    logic [7:0]  dp;
  } frame_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [DW-1:0] digit;
  frame_t        shadow, active;
  logic          shadow_full;
  logic          wrap, frame_wrap, pre_frame_wrap;
  logic          suppress;
  logic [3:0]    code_cur;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign wrap           = (presc == PW'(SCAN_DIV - 1));
  assign frame_wrap     = wrap && (digit == DW'(7));
  assign pre_frame_wrap = (presc == PW'(SCAN_DIV - 2)) && (digit == DW'(7));
  assign frame_ready    = ~shadow_full;

  // Slot state, prescaler and digit index advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      presc <= '0;
      digit <= '0;
    end else begin
      state <= state_nxt;
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) digit <= digit + DW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (wrap)
      state_nxt = BLANK;
    else if (presc == PW'(DEAD_CYC - 1))
      state_nxt = DRIVE;
  end

  always_comb begin
    an_d     = 8'hFF;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    code_cur = active.code[{digit, 2'b00} +: 4];
    if (state == DRIVE) begin
      seg_d = hex7(code_cur);
      dp_d  = ~active.dp[digit];
      if (active.en[digit] && !suppress)
        an_d = ~(8'h01 << digit);
    end
  end

  // frame_done is set one cycle early so it is high during the wrap cycle itself
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= pre_frame_wrap;
    end
  end

  // Transfer needs a full shadow and capture an empty one, so they never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      active      <= '0;
      shadow_full <= 1'b0;
    end else if (frame_wrap && shadow_full) begin
      active      <= shadow;
      shadow_full <= 1'b0;
    end else if (frame_valid && !shadow_full) begin
      shadow      <= {frame_code, frame_en, frame_dp};
      shadow_full <= 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  logic [PW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_wrap) begin
      if (blink_cnt == PW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + PW'(1);
      end
    end
  end

  assign suppress = blink_mask[digit] & ~blink_on;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, PW'(BLINK_FRAMES)};
  assign suppress     = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_seg_scan_ctrl;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 1;
  localparam int unsigned BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [31:0] frame_code = '0;
  logic [7:0]  frame_en = '0;
  logic [7:0]  frame_dp = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_code(frame_code), .frame_en(frame_en), .frame_dp(frame_dp),
    .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: cycles since reset release, displayed frame and pending frame
  int          n = 0;
  logic [31:0] m_code = '0, s_code = '0;
  logic [7:0]  m_en = '0, s_en = '0;
  logic [7:0]  m_dp = '0, s_dp = '0;
  logic        m_full = 1'b0;
  logic        captured = 1'b0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s n=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("an",          e.n, an,                 e.an);
      check("seg",         e.n, {1'b0, seg},        {1'b0, e.seg});
      check("dp",          e.n, {7'b0, dp},         {7'b0, e.dp});
      check("frame_done",  e.n, {7'b0, frame_done}, {7'b0, e.fd});
      check("frame_ready", e.n, {7'b0, frame_ready}, {7'b0, e.rdy});
    end
  end

  // Advance one clock, update the reference for that edge and queue the expected outputs
  task automatic tick();
    exp_t e;
    int m, p, d, f;
    logic sup;
    @(posedge clk);
    #1;
    e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
    if (rst) begin
      n = 0;
      m_code = '0; m_en = '0; m_dp = '0; m_full = 1'b0;
    end else begin
      n++;
      m = n - 1;
      p = m % SD;
      d = (m / SD) % 8;
      f = m / (SD * 8);
      sup = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      sup = blink_mask[d] && (((f / BF) % 2) == 1);
`endif
      if (p >= DC) begin
        e.seg = hex7(m_code[4*d +: 4]);
        e.dp  = ~m_dp[d];
        if (m_en[d] && !sup) e.an = ~(8'h01 << d);
      end
      e.fd = ((n % (SD * 8)) == (SD * 8 - 1));
      if ((n % (SD * 8)) == 0 && m_full) begin
        m_code = s_code; m_en = s_en; m_dp = s_dp; m_full = 1'b0;
      end else if (frame_valid && !m_full) begin
        s_code = frame_code; s_en = frame_en; s_dp = frame_dp; m_full = 1'b1;
        captured = 1'b1;
      end
    end
    e.n = n;
    e.rdy = ~m_full;
    expq.push_back(e);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic offer(input logic [31:0] c, input logic [7:0] en, input logic [7:0] dpv);
    frame_code = c; frame_en = en; frame_dp = dpv; frame_valid = 1'b1;
    captured = 1'b0;
    for (int i = 0; i < 200 && !captured; i++) tick();
    total++;
    if (!captured) begin
      bad++;
      $display("FAIL offer_timeout n=%0d got=not_accepted want=accepted", n);
    end
    frame_valid = 1'b0;
  endtask

  initial begin
    run(3);
    rst = 1'b0;
    // First frame: hex ramp, all digits on, dp on digit 0
    offer(32'h7654_3210, 8'hFF, 8'h01);
    run(39 - n);
    // Second frame mid-frame, then a third held until the shadow frees up
    offer(32'h89AB_CDEF, 8'h0F, 8'hF0);
    offer(32'hFEDC_BA98, 8'hFF, 8'h00);
    run(140 - n);
    blink_mask = 8'h01;
    run(300 - n);
    // Reset while digit 5 is being driven
    for (int i = 0; i < 64 && !((((n - 1) % 32) / 4 == 5) && (((n - 1) % 4) == 2)); i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(40);
    offer(32'h7654_3210, 8'hFF, 8'h01);
    run(70);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
